tx_burst_ctrl: RTL and testbench
================================

TX_BURST_CTRL -- requirements
Module: tx_burst_ctrl

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 9: signed I/Q sample width, modulator in and RF chain out.
REQ-002 SHALL have parameter MASK_WIDTH, default 8: ramp mask fraction bits; full scale is 2^MASK_WIDTH.
REQ-003 SHALL have parameter RAMP_LEN, default 64: ramp length in samples; power of two, <= 2^MASK_WIDTH.
REQ-004 SHALL have parameter PAYLOAD_LEN, default 142: payload bits per burst.
REQ-005 SHALL have parameter TAIL_SYMS, default 3: zero symbols sent before and after the payload.
REQ-006 SHALL have parameter GUARD_LEN, default 512: minimum clocks between bursts.
REQ-007 SHALL have parameter PRIME_SYMS, default 4: 1-symbols fed to flush the modulator.
REQ-008 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous, active-high.
REQ-009 SHALL have ports: fire_burst in 1; is_armed out 1; busy out 1; burst_done out 1 (one-cycle pulse); underrun out 1 (sticky).
REQ-010 SHALL have ports: bit_data in 1; bit_valid in 1; bit_ready out 1, payload valid/ready handshake.
REQ-011 SHALL have ports: symbol_strobe_i in 1; iq_symbol_edge_i in 1; current_symbol_o out 1.
REQ-012 SHALL have ports: modulator_inphase, modulator_quadrature in IQ_WIDTH signed; rfchain_inphase, rfchain_quadrature out IQ_WIDTH signed; iq_valid out 1.

Function
REQ-013 SHALL use a one-hot FSM: PRIME -> GUARD -> ARMED -> RAMPUP -> PAYLOAD -> RAMPDOWN -> GUARD.
REQ-014 PRIME: current_symbol_o=1; count symbol_strobe_i pulses; go to GUARD after PRIME_SYMS pulses.
REQ-015 GUARD: load counter with GUARD_LEN-1 on entry, decrement each clock, go to ARMED when it reaches 0.
REQ-016 ARMED: is_armed=1. fire_burst=1 latches a pending fire. Move to RAMPUP on the first iq_symbol_edge_i at or after the fire, including the same cycle.
REQ-017 fire_burst outside ARMED SHALL be ignored, not queued.
REQ-018 RAMPUP: mask = k*(2^MASK_WIDTH/RAMP_LEN) for sample k=0..RAMP_LEN-1, one sample per clock. After sample RAMP_LEN-1, go to PAYLOAD with mask = 2^MASK_WIDTH.
REQ-019 Symbol sequence is defined over symbol_strobe_i pulses from RAMPUP entry: TAIL_SYMS zeros, then PAYLOAD_LEN payload bits, then TAIL_SYMS zeros. If the sequence is exhausted, current_symbol_o=0.
REQ-020 bit_ready SHALL be 1 exactly in the cycle of a symbol_strobe_i that consumes a payload bit. A transfer is bit_valid & bit_ready.
REQ-021 If bit_valid=0 when a payload bit is consumed: send 0, set underrun, and still count the bit.
REQ-022 PAYLOAD exits to RAMPDOWN on the first iq_symbol_edge_i after the final tail symbol is issued.
REQ-023 RAMPDOWN: mask = (RAMP_LEN-1-k)*(2^MASK_WIDTH/RAMP_LEN) for k=0..RAMP_LEN-1. After the last sample, pulse burst_done and enter GUARD.
REQ-024 Outside RAMPUP, PAYLOAD and RAMPDOWN, mask SHALL be 0.
REQ-025 Datapath: register input samples (stage 1), then rf = (sample * mask) >>> MASK_WIDTH as a signed product with an unsigned (MASK_WIDTH+1)-bit mask, truncated to IQ_WIDTH (stage 2). Latency is 2 clocks, and mask is aligned to the stage-1 sample.
REQ-026 A full-scale mask SHALL pass samples bit-exact. A zero mask SHALL give exactly 0.
REQ-027 iq_valid SHALL equal (state in RAMPUP|PAYLOAD|RAMPDOWN) delayed 2 clocks.
REQ-028 busy=1 from RAMPUP entry until burst_done.
REQ-029 underrun SHALL clear on the next accepted fire.
REQ-030 symbol_strobe_i and iq_symbol_edge_i in the same cycle SHALL both be processed.

Reset
REQ-031 reset=1 SHALL asynchronously force PRIME, all counters 0, and these outputs: is_armed=0, busy=0, burst_done=0, underrun=0, bit_ready=0, current_symbol_o=0, iq_valid=0, rf outputs=0, pipeline registers=0.
REQ-032 Reset mid-burst SHALL abort the burst without a ramp-down and restart priming after release. Unconsumed payload bits are left untouched.

Verification
REQ-033 Defaults, symbol strobe every 12 clocks: after 4 strobes plus 512 clocks, is_armed=1.
REQ-034 fire_burst while is_armed=1, constant input I=+255, Q=-256: rf I ramps 0,3,7,...,251 (= floor(255*4k/256)), holds 255 in PAYLOAD, then mirrors down. 142 bit transfers occur, then burst_done=1 for 1 cycle.
REQ-035 Random payload with bit_valid held 1: current_symbol_o sequence = 3 zeros, payload, 3 zeros, and underrun=0.
REQ-036 Drop bit_valid for payload bit 50: that symbol is 0, underrun=1 until the next fire, and the burst is still 142 bits.
REQ-037 fire_burst during GUARD or PAYLOAD causes no state change. fire and iq_symbol_edge_i in the same ARMED cycle enter RAMPUP next clock.
REQ-038 Assert reset during PAYLOAD: all outputs 0 immediately, without waiting for a clock. After release, PRIME restarts and is_armed returns after priming plus guard.

Source files
------------

// File: rtl/tx_burst_ctrl.sv
// Burst transmit sequencer: primes the modulator, enforces a guard gap, then
// shapes one burst (ramp-up, payload, ramp-down) while feeding payload symbols.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// PRIME    | drive 1-symbols until PRIME_SYMS strobes have flushed the modulator
// GUARD    | wait GUARD_LEN clocks between bursts
// ARMED    | ready; a fire waits for the next symbol edge
// RAMPUP   | mask climbs 0 .. full-scale minus one step, one sample per clock
// PAYLOAD  | full-scale mask until the trailing tail symbols have been issued
// RAMPDOWN | mask falls back to 0, then burst_done
module tx_burst_ctrl #(
    parameter int IQ_WIDTH    = 9,
    parameter int MASK_WIDTH  = 8,
    parameter int RAMP_LEN    = 64,
    parameter int PAYLOAD_LEN = 142,
    parameter int TAIL_SYMS   = 3,
    parameter int GUARD_LEN   = 512,
    parameter int PRIME_SYMS  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fire_burst,
    output logic                       is_armed,
    output logic                       busy,
    output logic                       burst_done,
    output logic                       underrun,
    input  logic                       bit_data,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       symbol_strobe_i,
    input  logic                       iq_symbol_edge_i,
    output logic                       current_symbol_o,
    input  logic signed [IQ_WIDTH-1:0] modulator_inphase,
    input  logic signed [IQ_WIDTH-1:0] modulator_quadrature,
    output logic signed [IQ_WIDTH-1:0] rfchain_inphase,
    output logic signed [IQ_WIDTH-1:0] rfchain_quadrature,
    output logic                       iq_valid
);

    localparam int MSK_W   = MASK_WIDTH + 1;
    localparam int RAMP_W  = (RAMP_LEN > 1) ? $clog2(RAMP_LEN) : 1;
    localparam int STEP_SH = MASK_WIDTH - $clog2(RAMP_LEN);
    localparam int TMR_MAX = (GUARD_LEN > RAMP_LEN) ? GUARD_LEN : RAMP_LEN;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int SEQ_LEN = 2 * TAIL_SYMS + PAYLOAD_LEN;
    localparam int SYM_W   = $clog2(SEQ_LEN + 1);
    localparam int PRM_W   = $clog2(PRIME_SYMS + 1);
    localparam int PW      = IQ_WIDTH + MSK_W;

    localparam logic [TMR_W-1:0]  TMR_GUARD = TMR_W'(GUARD_LEN - 1);
    localparam logic [TMR_W-1:0]  TMR_RAMP  = TMR_W'(RAMP_LEN - 1);
    localparam logic [RAMP_W-1:0] RAMP_TOP  = RAMP_W'(RAMP_LEN - 1);
    localparam logic [SYM_W-1:0]  SYM_PL_LO = SYM_W'(TAIL_SYMS);
    localparam logic [SYM_W-1:0]  SYM_PL_HI = SYM_W'(TAIL_SYMS + PAYLOAD_LEN);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SEQ_LEN - 1);
    localparam logic [SYM_W-1:0]  SYM_END   = SYM_W'(SEQ_LEN);
    localparam logic [PRM_W-1:0]  PRM_LAST  = PRM_W'(PRIME_SYMS - 1);
    localparam logic [MSK_W-1:0]  MASK_FULL = {1'b1, {MASK_WIDTH{1'b0}}};

    typedef enum logic [5:0] {
        S_PRIME   = 6'b000001,
        S_GUARD   = 6'b000010,
        S_ARMED   = 6'b000100,
        S_RAMPUP  = 6'b001000,
        S_PAYLOAD = 6'b010000,
        S_RAMPDN  = 6'b100000
    } state_t;

    state_t             state, state_n;
    logic [TMR_W-1:0]   tmr, tmr_n;
    logic [PRM_W-1:0]   prm_cnt, prm_n;
    logic [SYM_W-1:0]   sym_cnt, sym_n;
    logic               pend, pend_n;
    logic               tail_done, tail_n;
    logic               cur_sym, cur_sym_n;
    logic               undr, undr_n;
    logic               in_burst;
    logic [RAMP_W-1:0]  ramp_idx;
    logic [MSK_W-1:0]   mask_c;

    logic signed [IQ_WIDTH-1:0] s1_i, s1_q;
    logic [MSK_W-1:0]           mask_r;
    logic                       v1, v2;
    logic signed [PW-1:0]       s1_i_x, s1_q_x, mask_x, prod_i, prod_q;

    assign in_burst = (state == S_RAMPUP) || (state == S_PAYLOAD) || (state == S_RAMPDN);

    always_comb begin
        state_n    = state;
        tmr_n      = tmr;
        prm_n      = prm_cnt;
        sym_n      = sym_cnt;
        pend_n     = pend;
        tail_n     = tail_done;
        cur_sym_n  = cur_sym;
        undr_n     = undr;
        bit_ready  = 1'b0;
        burst_done = 1'b0;
        ramp_idx   = '0;
        mask_c     = '0;

        // Symbol sequencing runs on strobes across all three burst states.
        if (in_burst && symbol_strobe_i) begin
            if (sym_cnt != SYM_END)
                sym_n = sym_cnt + 1'b1;
            if (sym_cnt >= SYM_PL_LO && sym_cnt < SYM_PL_HI) begin
                bit_ready = 1'b1;
                cur_sym_n = bit_valid & bit_data;
                if (!bit_valid)
                    undr_n = 1'b1;
            end else begin
                cur_sym_n = 1'b0;
            end
            if (sym_cnt == SYM_LAST)
                tail_n = 1'b1;
        end

        case (state)
            S_PRIME: begin
                cur_sym_n = 1'b1;
                if (symbol_strobe_i) begin
                    if (prm_cnt == PRM_LAST) begin
                        state_n = S_GUARD;
                        tmr_n   = TMR_GUARD;
                        prm_n   = '0;
                    end else begin
                        prm_n = prm_cnt + 1'b1;
                    end
                end
            end
            S_GUARD: begin
                cur_sym_n = 1'b0;
                if (tmr == '0) begin
                    state_n = S_ARMED;
                    pend_n  = 1'b0;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            S_ARMED: begin
                cur_sym_n = 1'b0;
                if (fire_burst) begin
                    pend_n = 1'b1;
                    undr_n = 1'b0;
                end
                if ((pend || fire_burst) && iq_symbol_edge_i) begin
                    state_n = S_RAMPUP;
                    tmr_n   = TMR_RAMP;
                    pend_n  = 1'b0;
                    sym_n   = '0;
                    tail_n  = 1'b0;
                end
            end
            S_RAMPUP: begin
                // Timer counts down, so the ramp index is its complement.
                ramp_idx = RAMP_TOP - tmr[RAMP_W-1:0];
                mask_c   = MSK_W'(ramp_idx) << STEP_SH;
                if (tmr == '0)
                    state_n = S_PAYLOAD;
                else
                    tmr_n = tmr - 1'b1;
            end
            S_PAYLOAD: begin
                mask_c = MASK_FULL;
                if (tail_done && iq_symbol_edge_i) begin
                    state_n = S_RAMPDN;
                    tmr_n   = TMR_RAMP;
                end
            end
            S_RAMPDN: begin
                ramp_idx = tmr[RAMP_W-1:0];
                mask_c   = MSK_W'(ramp_idx) << STEP_SH;
                if (tmr == '0) begin
                    state_n    = S_GUARD;
                    tmr_n      = TMR_GUARD;
                    burst_done = 1'b1;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            default: state_n = S_PRIME;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_PRIME;
            tmr       <= '0;
            prm_cnt   <= '0;
            sym_cnt   <= '0;
            pend      <= 1'b0;
            tail_done <= 1'b0;
            cur_sym   <= 1'b0;
            undr      <= 1'b0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            prm_cnt   <= prm_n;
            sym_cnt   <= sym_n;
            pend      <= pend_n;
            tail_done <= tail_n;
            cur_sym   <= cur_sym_n;
            undr      <= undr_n;
        end
    end

    // Mask is registered alongside the stage-1 samples so both line up.
    assign s1_i_x = PW'(s1_i);
    assign s1_q_x = PW'(s1_q);
    assign mask_x = $signed(PW'(mask_r));
    assign prod_i = s1_i_x * mask_x;
    assign prod_q = s1_q_x * mask_x;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_i               <= '0;
            s1_q               <= '0;
            mask_r             <= '0;
            v1                 <= 1'b0;
            v2                 <= 1'b0;
            rfchain_inphase    <= '0;
            rfchain_quadrature <= '0;
        end else begin
            s1_i               <= modulator_inphase;
            s1_q               <= modulator_quadrature;
            mask_r             <= mask_c;
            v1                 <= in_burst;
            v2                 <= v1;
            rfchain_inphase    <= IQ_WIDTH'(prod_i >>> MASK_WIDTH);
            rfchain_quadrature <= IQ_WIDTH'(prod_q >>> MASK_WIDTH);
        end
    end

    assign is_armed         = (state == S_ARMED);
    assign busy             = in_burst;
    assign current_symbol_o = cur_sym;
    assign underrun         = undr;
    assign iq_valid         = v2;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Directed bench for tx_burst_ctrl: priming/guard timing, burst shaping,
// symbol sequence, underrun, fire filtering and asynchronous reset.
module tb_tx_burst_ctrl;

    localparam int PAYLOAD_LEN = 142;
    localparam int SEQ_LEN     = 148;
    localparam int RAMP        = 64;
    localparam int ARM_LAT     = 550;

    logic clock = 1'b0;
    logic reset;
    logic fire_burst, bit_data, bit_valid, bit_ready;
    logic symbol_strobe_i, iq_symbol_edge_i, current_symbol_o;
    logic is_armed, busy, burst_done, underrun, iq_valid;
    logic signed [8:0] mod_i, mod_q, rf_i, rf_q;

    logic gen_en, gen_strobe, gen_edge, man_edge;
    int   ph;

    logic payload [0:PAYLOAD_LEN-1];
    int   bit_idx;
    logic drop_bit;

    int   n_cmp = 0, n_bad = 0;
    logic collect, rf_en, adv, sym_pend;
    int   symq[$], qi[$], qq[$];
    int   nconsume, nxfer, ndone, nbusy, nvalid;

    typedef struct {
        int in_i;
        int in_q;
        int exp_i;
        int exp_q;
    } vec_t;
    vec_t vecs[8];

    always #5 clock = ~clock;

    assign symbol_strobe_i  = gen_strobe;
    assign iq_symbol_edge_i = gen_edge | man_edge;
    assign bit_data  = (bit_idx < PAYLOAD_LEN) ? payload[bit_idx] : 1'b0;
    assign bit_valid = !(drop_bit && bit_idx == 50);

    tx_burst_ctrl dut (
        .clock               (clock),
        .reset               (reset),
        .fire_burst          (fire_burst),
        .is_armed            (is_armed),
        .busy                (busy),
        .burst_done          (burst_done),
        .underrun            (underrun),
        .bit_data            (bit_data),
        .bit_valid           (bit_valid),
        .bit_ready           (bit_ready),
        .symbol_strobe_i     (symbol_strobe_i),
        .iq_symbol_edge_i    (iq_symbol_edge_i),
        .current_symbol_o    (current_symbol_o),
        .modulator_inphase   (mod_i),
        .modulator_quadrature(mod_q),
        .rfchain_inphase     (rf_i),
        .rfchain_quadrature  (rf_q),
        .iq_valid            (iq_valid)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe on phase 0, symbol edge on phase 6 of a 12-clock symbol.
    initial begin
        gen_strobe = 1'b0;
        gen_edge   = 1'b0;
        ph         = 0;
        forever begin
            @(posedge clock);
            #1;
            if (gen_en) begin
                gen_strobe = (ph == 0);
                gen_edge   = (ph == 6);
                ph = (ph == 11) ? 0 : ph + 1;
            end else begin
                gen_strobe = 1'b0;
                gen_edge   = 1'b0;
                ph         = 0;
            end
        end
    end

    initial begin
        adv = 1'b0;
        sym_pend = 1'b0;
        forever begin
            @(negedge clock);
            if (adv) begin
                bit_idx++;
                adv = 1'b0;
            end
            if (sym_pend)
                symq.push_back(int'(current_symbol_o));
            sym_pend = collect && symbol_strobe_i && busy;
            if (collect && bit_ready) begin
                nconsume++;
                if (bit_valid) nxfer++;
                adv = 1'b1;
            end
            if (collect && burst_done) ndone++;
            if (rf_en) begin
                if (busy) nbusy++;
                if (iq_valid) begin
                    nvalid++;
                    qi.push_back(int'(rf_i));
                    qq.push_back(int'(rf_q));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_is_armed"},   int'(is_armed), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_burst_done"}, int'(burst_done), 0);
        check({tag, "_underrun"},   int'(underrun), 0);
        check({tag, "_bit_ready"},  int'(bit_ready), 0);
        check({tag, "_cur_sym"},    int'(current_symbol_o), 0);
        check({tag, "_iq_valid"},   int'(iq_valid), 0);
        check({tag, "_rf_i"},       int'(rf_i), 0);
        check({tag, "_rf_q"},       int'(rf_q), 0);
    endtask

    task automatic run_to_armed(input string tag);
        int cnt;
        cnt = 0;
        while (!is_armed && cnt < 2000) begin
            @(negedge clock);
            cnt++;
            if (cnt == 5)   check({tag, "_prime_sym"}, int'(current_symbol_o), 1);
            if (cnt == 100) fire_burst = 1'b1;
            if (cnt == 101) fire_burst = 1'b0;
        end
        check({tag, "_arm_latency"}, cnt, ARM_LAT);
    endtask

    task automatic wait_armed(input string tag);
        int cnt;
        cnt = 0;
        while (!is_armed && cnt < 700) begin
            @(negedge clock);
            cnt++;
        end
        check({tag, "_rearmed"}, int'(is_armed), 1);
    endtask

    task automatic pulse_fire();
        @(negedge clock);
        fire_burst = 1'b1;
        @(negedge clock);
        fire_burst = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int cnt;
        cnt = 0;
        while (!busy && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        check({tag, "_burst_start"}, int'(busy), 1);
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while (!burst_done && cnt < 4000) begin
            @(negedge clock);
            cnt++;
        end
        check({tag, "_done_seen"}, int'(burst_done), 1);
    endtask

    task automatic start_burst(input bit drop);
        for (int i = 0; i < PAYLOAD_LEN; i++) payload[i] = 1'($urandom_range(0, 1));
        if (drop) payload[50] = 1'b1;
        drop_bit = drop;
        bit_idx  = 0;
        nconsume = 0;
        nxfer    = 0;
        ndone    = 0;
        symq.delete();
        collect  = 1'b1;
    endtask

    task automatic check_symbols(input string tag);
        int errs, exp;
        errs = 0;
        for (int i = 0; i < symq.size(); i++) begin
            exp = 0;
            if (i >= 3 && i < 3 + PAYLOAD_LEN)
                exp = (drop_bit && i == 53) ? 0 : int'(payload[i-3]);
            if (symq[i] != exp) errs++;
        end
        check({tag, "_sym_count_ok"}, int'(symq.size() >= SEQ_LEN), 1);
        check({tag, "_sym_errors"}, errs, 0);
    endtask

    initial begin
        int errs, n;
        vecs[0] = '{255, -256, 255, -256};
        vecs[1] = '{-256, 255, -256, 255};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{-1, 1, -1, 1};
        vecs[4] = '{1, -1, 1, -1};
        vecs[5] = '{100, -100, 100, -100};
        vecs[6] = '{-129, 128, -129, 128};
        vecs[7] = '{37, -200, 37, -200};

        reset = 1'b1; gen_en = 1'b0; man_edge = 1'b0; fire_burst = 1'b0;
        mod_i = 9'(255); mod_q = 9'(-256);
        collect = 1'b0; rf_en = 1'b0; drop_bit = 1'b0; bit_idx = 0;
        nconsume = 0; nxfer = 0; ndone = 0; nbusy = 0; nvalid = 0;
        for (int i = 0; i < PAYLOAD_LEN; i++) payload[i] = 1'b0;

        repeat (3) @(negedge clock);
        check_zero_outputs("reset");

        reset = 1'b0;
        gen_en = 1'b1;
        run_to_armed("init");
        repeat (30) @(negedge clock);
        check("guard_fire_ignored_busy", int'(busy), 0);
        check("guard_fire_ignored_armed", int'(is_armed), 1);

        // Burst 1: constant I/Q, clean payload, stray fire in PAYLOAD.
        start_burst(1'b0);
        qi.delete(); qq.delete(); nbusy = 0; nvalid = 0;
        rf_en = 1'b1;
        pulse_fire();
        wait_busy("b1");
        repeat (300) @(negedge clock);
        check("b1_busy_in_payload", int'(busy), 1);
        pulse_fire();
        wait_done("b1");
        check("b1_xfers_at_done", nxfer, PAYLOAD_LEN);
        check("b1_consumed", nconsume, PAYLOAD_LEN);
        @(negedge clock);
        check("b1_done_cleared", int'(burst_done), 0);
        repeat (4) @(negedge clock);
        collect = 1'b0;
        rf_en = 1'b0;
        check("b1_done_width", ndone, 1);
        check("b1_underrun", int'(underrun), 0);
        check_symbols("b1");
        check("b1_valid_vs_busy", nvalid, nbusy);
        n = qi.size();
        check("b1_sample_count_ok", int'(n >= 2 * RAMP), 1);
        errs = 0;
        if (n >= 2 * RAMP) begin
            for (int k = 0; k < RAMP; k++) begin
                if (qi[k] != (255 * 4 * k) / 256) errs++;
                if (qq[k] != -4 * k) errs++;
                if (qi[n-1-k] != (255 * 4 * k) / 256) errs++;
                if (qq[n-1-k] != -4 * k) errs++;
            end
            for (int k = RAMP; k < n - RAMP; k++) begin
                if (qi[k] != 255) errs++;
                if (qq[k] != -256) errs++;
            end
        end
        check("b1_shape_errors", errs, 0);
        check("b1_ramp_i_step1", qi.size() > 1 ? qi[1] : -999, 3);
        check("b1_ramp_i_last", qi.size() > RAMP ? qi[RAMP-1] : -999, 251);

        repeat (10) @(negedge clock);
        check("zero_mask_rf_i", int'(rf_i), 0);
        check("zero_mask_rf_q", int'(rf_q), 0);
        check("zero_mask_iq_valid", int'(iq_valid), 0);
        check("guard_after_burst", int'(is_armed), 0);
        wait_armed("b1");
        repeat (30) @(negedge clock);
        check("payload_fire_not_queued", int'(busy), 0);

        // Burst 2: payload bit 50 starved; full-scale datapath vectors.
        start_burst(1'b1);
        pulse_fire();
        wait_busy("b2");
        repeat (100) @(negedge clock);
        foreach (vecs[j]) begin
            mod_i = 9'(vecs[j].in_i);
            mod_q = 9'(vecs[j].in_q);
            repeat (3) @(negedge clock);
            check($sformatf("vec%0d_rf_i", j), int'(rf_i), vecs[j].exp_i);
            check($sformatf("vec%0d_rf_q", j), int'(rf_q), vecs[j].exp_q);
        end
        check("vec_iq_valid", int'(iq_valid), 1);
        mod_i = 9'(255); mod_q = 9'(-256);
        wait_done("b2");
        @(negedge clock);
        collect = 1'b0;
        check("b2_consumed", nconsume, PAYLOAD_LEN);
        check("b2_xfers", nxfer, PAYLOAD_LEN - 1);
        check("b2_underrun", int'(underrun), 1);
        check_symbols("b2");
        wait_armed("b2");
        check("underrun_sticky", int'(underrun), 1);

        // Burst 3: fire and edge together, then reset in PAYLOAD.
        gen_en = 1'b0;
        drop_bit = 1'b0;
        repeat (2) @(negedge clock);
        fire_burst = 1'b1;
        man_edge = 1'b1;
        check("same_cycle_pre_busy", int'(busy), 0);
        @(negedge clock);
        fire_burst = 1'b0;
        man_edge = 1'b0;
        check("same_cycle_rampup", int'(busy), 1);
        check("underrun_cleared", int'(underrun), 0);
        gen_en = 1'b1;
        repeat (200) @(negedge clock);
        check("b3_busy_before_reset", int'(busy), 1);
        check("b3_valid_before_reset", int'(iq_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async");
        @(negedge clock);
        gen_en = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        gen_en = 1'b1;
        run_to_armed("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
